rob_dispatch_alloc: RTL

Write-side allocator for the reorder buffer.
- Accepts up to DISPATCH_WIDTH in-order instructions per cycle from dispatch and assigns each a ROB index from a circular tail pointer.
- Steers each entry into the banked ROB FIFOs, where ROB index i lives in bank i mod DISPATCH_WIDTH.
- Tracks occupancy against the retire count reported by the ROB read side, and provides flush recovery.

---
 rtl/rob_dispatch_alloc.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rob_dispatch_alloc.sv
// rob_dispatch_alloc: ROB write-side allocator. Assigns circular ROB indices
// to up to DISPATCH_WIDTH in-order dispatch slots, steers them to the banks
// (bank = idx mod DISPATCH_WIDTH), tracks occupancy and handles flush.
// Ports: clk/rst (sync, active-high); disp_valid/disp_dst_reg in;
// disp_ready/disp_rob_idx out (comb); retire_cnt/flush in;
// bank_w_en/bank_w_data out (registered); tail_ptr/rob_count/rob_empty/
// rob_full/alloc_err status out.
// Option: define ROB_ALLOC_PARTIAL_EN to admit groups smaller than
// DISPATCH_WIDTH when fewer than DISPATCH_WIDTH entries are free.
module rob_dispatch_alloc #(
    parameter int NUM_ROB_ENTS   = 64,
    parameter int DISPATCH_WIDTH = 4,
    parameter int DST_REG_BITS   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic [DISPATCH_WIDTH-1:0] disp_valid,
    input  logic [DISPATCH_WIDTH*DST_REG_BITS-1:0] disp_dst_reg,
    output logic disp_ready,
    output logic [DISPATCH_WIDTH*$clog2(NUM_ROB_ENTS)-1:0] disp_rob_idx,
    input  logic [$clog2(DISPATCH_WIDTH):0] retire_cnt,
    input  logic flush,
    output logic [DISPATCH_WIDTH-1:0] bank_w_en,
    output logic [DISPATCH_WIDTH*DST_REG_BITS-1:0] bank_w_data,
    output logic [$clog2(NUM_ROB_ENTS)-1:0] tail_ptr,
    output logic [$clog2(NUM_ROB_ENTS):0] rob_count,
    output logic rob_empty,
    output logic rob_full,
    output logic alloc_err
);
    localparam int IW = $clog2(NUM_ROB_ENTS);
    localparam int CW = IW + 1;
    localparam int SW = CW + 1;
    localparam int RW = $clog2(DISPATCH_WIDTH) + 1;
    localparam int BW = $clog2(DISPATCH_WIDTH);
    localparam int DB = DST_REG_BITS;
    localparam int DW = DISPATCH_WIDTH;

    logic [IW-1:0] tail_q, tail_d;
    logic [IW-1:0] head_q, head_d;
    logic [CW-1:0] count_q, count_d;
    logic err_q, err_d;
    logic [DW-1:0] wen_q, wen_d;
    logic [DW*DB-1:0] wdata_q, wdata_d;

    logic [RW-1:0] n_disp;
    logic run;
    logic [CW-1:0] free;
    logic accept;
    logic [BW-1:0] bank;
    logic [SW-1:0] sum;
    logic underflow;

    // Count of leading contiguous valid slots; later slots are ignored.
    always_comb begin
        n_disp = '0;
        run = 1'b1;
        for (int k = 0; k < DW; k++) begin
            if (run && disp_valid[k]) begin
                n_disp = n_disp + RW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    assign free = CW'(NUM_ROB_ENTS) - count_q;

`ifdef ROB_ALLOC_PARTIAL_EN
    assign disp_ready = ~flush & (free >= CW'(n_disp));
`else
    assign disp_ready = ~flush & (free >= CW'(DW));
`endif

    assign accept = disp_ready & (n_disp != '0);

    always_comb begin
        for (int k = 0; k < DW; k++) begin
            disp_rob_idx[k*IW +: IW] = tail_q + IW'(k);
        end
    end

    // Slot k lands in bank (tail+k) mod DW; the group never splits.
    always_comb begin
        wen_d = '0;
        wdata_d = '0;
        bank = '0;
        if (accept) begin
            for (int k = 0; k < DW; k++) begin
                if (RW'(k) < n_disp) begin
                    bank = tail_q[BW-1:0] + BW'(k);
                    wen_d[bank] = 1'b1;
                    wdata_d[bank*DB +: DB] = disp_dst_reg[k*DB +: DB];
                end
            end
        end
    end

    // Occupancy: dispatch and retire both apply; underflow saturates at 0.
    always_comb begin
        sum = SW'(count_q) + (accept ? SW'(n_disp) : SW'(0));
        underflow = SW'(retire_cnt) > sum;
        head_d = head_q + IW'(retire_cnt);
        err_d = err_q | underflow;
        count_d = underflow ? '0 : CW'(sum - SW'(retire_cnt));
        tail_d = tail_q;
        if (flush) begin
            count_d = '0;
            tail_d = head_d;
        end else if (accept) begin
            tail_d = tail_q + IW'(n_disp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tail_q  <= '0;
            head_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            wen_q   <= '0;
            wdata_q <= '0;
        end else begin
            tail_q  <= tail_d;
            head_q  <= head_d;
            count_q <= count_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
        end
    end

    assign bank_w_en   = wen_q;
    assign bank_w_data = wdata_q;
    assign tail_ptr    = tail_q;
    assign rob_count   = count_q;
    assign rob_empty   = (count_q == '0);
    assign rob_full    = (count_q == CW'(NUM_ROB_ENTS));
    assign alloc_err   = err_q;

endmodule
